// File: rtl/adc_sample_averager_if.sv
// Sample-in / block-average-out bundle for adc_sample_averager.
// ADC_CAPTURE_PEAK_EN adds the min_o/max_o block extremes.
interface adc_sample_averager_if;
    logic [13:0] adc_d_i;
    logic        adc_otr_i;
    logic        en_i;
    logic        clr_i;
    logic [13:0] avg_o;
    logic        avg_valid_o;
    logic        avg_ready_i;
    logic [7:0]  otr_cnt_o;
    logic        drop_o;
`ifdef ADC_CAPTURE_PEAK_EN
    logic [13:0] min_o;
    logic [13:0] max_o;
`endif

    modport master (
        input  adc_d_i, adc_otr_i, en_i, clr_i, avg_ready_i,
        output avg_o, avg_valid_o, otr_cnt_o, drop_o
`ifdef ADC_CAPTURE_PEAK_EN
        , output min_o, max_o
`endif
    );

    modport slave (
        output adc_d_i, adc_otr_i, en_i, clr_i, avg_ready_i,
        input  avg_o, avg_valid_o, otr_cnt_o, drop_o
`ifdef ADC_CAPTURE_PEAK_EN
        , input min_o, max_o
`endif
    );
endinterface

// File: rtl/adc_sample_averager.sv
// ADC capture, offset-binary to two's complement with over-range clamp, and 2^LOG2_N block averaging.
// ADC_CAPTURE_PEAK_EN adds per-block signed min/max alongside the average.
module adc_sample_averager #(
    parameter int LOG2_N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_sample_averager_if.master bus
);
    localparam int AW = 14 + LOG2_N;
    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    // S1 is plain capture so it can live in the I/O cells; clr is applied from S2 on.
    logic [13:0]        s1_d_q, s1_d_d;
    logic               s1_otr_q, s1_otr_d;
    logic               s1_en_q, s1_en_d;
    logic signed [13:0] s2_s_q, s2_s_d;
    logic               s2_otr_q, s2_otr_d;
    logic               s2_en_q, s2_en_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         otr_acc_q, otr_acc_d;
    logic [13:0]        res_avg_q, res_avg_d;
    logic [7:0]         res_otr_q, res_otr_d;
    logic               res_vld_q, res_vld_d;
    logic [13:0]        avg_q, avg_d;
    logic               avg_valid_q, avg_valid_d;
    logic [7:0]         otr_cnt_q, otr_cnt_d;
    logic               drop_q, drop_d;
    logic signed [AW-1:0] sum;
    logic [7:0]         otr_next;
    logic               blk_end;
`ifdef ADC_CAPTURE_PEAK_EN
    logic signed [13:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic signed [13:0] res_min_q, res_min_d, res_max_q, res_max_d;
    logic [13:0]        min_q, min_d, max_q, max_d;
    logic signed [13:0] blk_min, blk_max;
`endif

    always_comb begin
        s1_d_d      = bus.adc_d_i;
        s1_otr_d    = bus.adc_otr_i;
        s1_en_d     = bus.en_i;
        s2_otr_d    = s1_otr_q;
        s2_en_d     = s1_en_q & ~bus.clr_i;
        if (s1_otr_q)
            s2_s_d = s1_d_q[13] ? 14'sh1FFF : 14'sh2000;
        else
            s2_s_d = {~s1_d_q[13], s1_d_q[12:0]};

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        otr_acc_d   = otr_acc_q;
        res_avg_d   = res_avg_q;
        res_otr_d   = res_otr_q;
        res_vld_d   = 1'b0;
        sum         = acc_q + AW'(s2_s_q);
        otr_next    = (s2_otr_q && otr_acc_q != 8'hFF) ? otr_acc_q + 8'd1 : otr_acc_q;
        blk_end     = (cnt_q == CNT_LAST);
`ifdef ADC_CAPTURE_PEAK_EN
        run_min_d   = run_min_q;
        run_max_d   = run_max_q;
        res_min_d   = res_min_q;
        res_max_d   = res_max_q;
        blk_min     = (cnt_q == '0 || s2_s_q < run_min_q) ? s2_s_q : run_min_q;
        blk_max     = (cnt_q == '0 || s2_s_q > run_max_q) ? s2_s_q : run_max_q;
`endif

        if (bus.clr_i) begin
            acc_d     = '0;
            cnt_d     = '0;
            otr_acc_d = '0;
`ifdef ADC_CAPTURE_PEAK_EN
            run_min_d = '0;
            run_max_d = '0;
`endif
        end else if (s2_en_q) begin
            if (blk_end) begin
                res_avg_d = 14'(sum >>> LOG2_N);
                res_otr_d = otr_next;
                res_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                otr_acc_d = '0;
`ifdef ADC_CAPTURE_PEAK_EN
                res_min_d = blk_min;
                res_max_d = blk_max;
                run_min_d = '0;
                run_max_d = '0;
`endif
            end else begin
                acc_d     = sum;
                cnt_d     = cnt_q + 1'b1;
                otr_acc_d = otr_next;
`ifdef ADC_CAPTURE_PEAK_EN
                run_min_d = blk_min;
                run_max_d = blk_max;
`endif
            end
        end

        avg_d       = avg_q;
        otr_cnt_d   = otr_cnt_q;
        avg_valid_d = avg_valid_q;
        drop_d      = drop_q;
`ifdef ADC_CAPTURE_PEAK_EN
        min_d       = min_q;
        max_d       = max_q;
`endif
        if (avg_valid_q && bus.avg_ready_i)
            avg_valid_d = 1'b0;
        // A result still in flight when clr arrives is treated as part of the flushed block.
        if (res_vld_q && !bus.clr_i) begin
            if (!avg_valid_q || bus.avg_ready_i) begin
                avg_d       = res_avg_q;
                otr_cnt_d   = res_otr_q;
                avg_valid_d = 1'b1;
`ifdef ADC_CAPTURE_PEAK_EN
                min_d       = res_min_q;
                max_d       = res_max_q;
`endif
            end else begin
                drop_d = 1'b1;
            end
        end
        if (bus.clr_i)
            drop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_d_q      <= '0;
            s1_otr_q    <= 1'b0;
            s1_en_q     <= 1'b0;
            s2_s_q      <= '0;
            s2_otr_q    <= 1'b0;
            s2_en_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            otr_acc_q   <= '0;
            res_avg_q   <= '0;
            res_otr_q   <= '0;
            res_vld_q   <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            otr_cnt_q   <= '0;
            drop_q      <= 1'b0;
`ifdef ADC_CAPTURE_PEAK_EN
            run_min_q   <= '0;
            run_max_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            min_q       <= '0;
            max_q       <= '0;
`endif
        end else begin
            s1_d_q      <= s1_d_d;
            s1_otr_q    <= s1_otr_d;
            s1_en_q     <= s1_en_d;
            s2_s_q      <= s2_s_d;
            s2_otr_q    <= s2_otr_d;
            s2_en_q     <= s2_en_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            otr_acc_q   <= otr_acc_d;
            res_avg_q   <= res_avg_d;
            res_otr_q   <= res_otr_d;
            res_vld_q   <= res_vld_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            otr_cnt_q   <= otr_cnt_d;
            drop_q      <= drop_d;
`ifdef ADC_CAPTURE_PEAK_EN
            run_min_q   <= run_min_d;
            run_max_q   <= run_max_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            min_q       <= min_d;
            max_q       <= max_d;
`endif
        end
    end

    assign bus.avg_o       = avg_q;
    assign bus.avg_valid_o = avg_valid_q;
    assign bus.otr_cnt_o   = otr_cnt_q;
    assign bus.drop_o      = drop_q;
`ifdef ADC_CAPTURE_PEAK_EN
    assign bus.min_o       = min_q;
    assign bus.max_o       = max_q;
`endif
endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager with LOG2_N=4; expected block results are hand-computed.
module tb_adc_sample_averager;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [13:0] avg;
        logic [7:0]  otr;
        logic [13:0] mn;
        logic [13:0] mx;
    } exp_t;
    exp_t exp_q[$];

    adc_sample_averager_if bus();

    adc_sample_averager #(.LOG2_N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [13:0] avg, input logic [7:0] otr,
                            input logic [13:0] mn, input logic [13:0] mx);
        exp_t e;
        e.avg = avg; e.otr = otr; e.mn = mn; e.mx = mx;
        exp_q.push_back(e);
    endtask

    // Apply one input vector; it is captured by the next rising edge.
    task automatic drive(input logic [13:0] d, input logic otr, input logic en);
        bus.adc_d_i   = d;
        bus.adc_otr_i = otr;
        bus.en_i      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(14'h0, 1'b0, 1'b0);
    endtask

    task automatic block(input logic [13:0] d, input int n);
        for (int i = 0; i < n; i++) drive(d, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.avg_valid_o && bus.avg_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual avg=%h otr=%0d expected none", bus.avg_o, bus.otr_cnt_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_avg", bus.avg_o, e.avg);
                check("sb_otr_cnt", bus.otr_cnt_o, e.otr);
`ifdef ADC_CAPTURE_PEAK_EN
                check("sb_min", bus.min_o, e.mn);
                check("sb_max", bus.max_o, e.mx);
`endif
            end
        end
    end

    initial begin
        bus.adc_d_i = '0; bus.adc_otr_i = 1'b0; bus.en_i = 1'b0;
        bus.clr_i = 1'b0; bus.avg_ready_i = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_avg", bus.avg_o, 0);
        check("rst_valid", bus.avg_valid_o, 0);
        check("rst_otr_cnt", bus.otr_cnt_o, 0);
        check("rst_drop", bus.drop_o, 0);

        // Mid-scale input averages to zero; valid rises 3 edges after the last sample, for one cycle.
        push_exp(14'h0000, 8'd0, 14'h0000, 14'h0000);
        block(14'h2000, 16);
        bus.en_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("latency_valid_edge%0d", k), bus.avg_valid_o, (k == 3) ? 1 : 0);
        end

        push_exp(14'h3FFF, 8'd0, 14'h2000, 14'h1FFF);
        for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? 14'h3FFF : 14'h0000, 1'b0, 1'b1);
        idle(5);

        // Four clamped negative over-range samples among mid-scale samples.
        push_exp(14'h3800, 8'd4, 14'h2000, 14'h0000);
        for (int i = 0; i < 4; i++) drive(14'h0000, 1'b1, 1'b1);
        block(14'h2000, 12);
        idle(5);

        // Back-pressure across two block ends: first retained, second dropped.
        bus.avg_ready_i = 1'b0;
        block(14'h2100, 16);
        block(14'h1F00, 16);
        idle(6);
        check("hold_valid", bus.avg_valid_o, 1);
        check("hold_avg", bus.avg_o, 14'h0100);
        check("drop_set", bus.drop_o, 1);
        push_exp(14'h0100, 8'd0, 14'h0100, 14'h0100);
        bus.avg_ready_i = 1'b1;
        @(posedge clk); #1;
        check("valid_after_xfer", bus.avg_valid_o, 0);
        bus.clr_i = 1'b1;
        idle(1);
        bus.clr_i = 1'b0;
        check("drop_cleared", bus.drop_o, 0);
        check("clr_keeps_avg", bus.avg_o, 14'h0100);

        push_exp(14'h0100, 8'd0, 14'h0100, 14'h0100);
        for (int i = 0; i < 32; i++) drive(14'h2100, 1'b0, (i % 2 == 0));
        idle(5);

        // clr discards a partial block.
        block(14'h0000, 5);
        bus.clr_i = 1'b1;
        idle(1);
        bus.clr_i = 1'b0;
        push_exp(14'h0080, 8'd0, 14'h0080, 14'h0080);
        block(14'h2080, 16);
        idle(5);

        // rst with a pending result and a partial block in flight.
        bus.avg_ready_i = 1'b0;
        block(14'h2100, 16);
        idle(5);
        check("pending_before_rst", bus.avg_valid_o, 1);
        block(14'h0000, 10);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst2_avg", bus.avg_o, 0);
        check("rst2_valid", bus.avg_valid_o, 0);
        check("rst2_otr_cnt", bus.otr_cnt_o, 0);
        check("rst2_drop", bus.drop_o, 0);
        bus.avg_ready_i = 1'b1;
        push_exp(14'h0400, 8'd0, 14'h0400, 14'h0400);
        block(14'h2400, 16);
        idle(10);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
